adc_sum_sq_ctrl: RTL and testbench

- Sequences the ADC power monitor: squares signed ADC samples, accumulates them over a programmable window of 2^acc_len samples, and publishes each completed window sum to a 32-bit simulink2ppc status register (user_data_in).
- Window start aligns to an external sync pulse.
- Sits in the user_clk domain between the ADC sample stream and the software-readable sum_sq register. Enable, length and resync controls come from a ppc2simulink control register.

---
 rtl/adc_ctrl_pkg.sv | 23 ++
 rtl/sum_sq_pipe.sv | 89 ++++++++
 rtl/adc_sum_sq_ctrl.sv | 110 +++++++++++
 tb/tb_adc_sum_sq_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/adc_ctrl_pkg.sv
// Shared definitions for the ADC power-monitor controller.
package adc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    ACCUM     = 2'd2
  } state_t;

  // Legal range of log2 window length.
  localparam int LEN_MIN = 4;
  localparam int LEN_MAX = 16;

  // Pull a requested log2 window length into [lo, hi].
  function automatic int unsigned clamp_len(input int unsigned len,
                                            input int unsigned lo,
                                            input int unsigned hi);
    if (len < lo) return lo;
    if (len > hi) return hi;
    return len;
  endfunction

endpackage

// File: rtl/sum_sq_pipe.sv
// Square-and-accumulate datapath: square register, saturating window
// accumulator and publication of each finished window sum.
module sum_sq_pipe #(
  parameter int ADC_W = 8,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  input  logic                    in_vld,
  input  logic                    in_last,
  input  logic signed [ADC_W-1:0] in_data,
  output logic [ACC_W-1:0]        sum_out,
  output logic                    dump_valid,
  output logic [15:0]             dump_cnt,
  output logic                    sat_flag
);

  // Returns {overflow, value}; value pins at all-ones on overflow.
  function automatic logic [ACC_W:0] sat_add(input logic [ACC_W-1:0]   a,
                                             input logic [2*ADC_W-1:0] b);
    logic [ACC_W:0] w;
    w = {1'b0, a} + {{(ACC_W + 1 - 2*ADC_W){1'b0}}, b};
    if (w[ACC_W]) return {1'b1, {ACC_W{1'b1}}};
    return w;
  endfunction

  logic signed [2*ADC_W-1:0] d_ext;
  logic signed [2*ADC_W-1:0] prod;
  logic [2*ADC_W-1:0]        sq_p1;
  logic                      vld_p1;
  logic                      last_p1;
  logic [ACC_W-1:0]          acc_p2;
  logic                      sat_win_p2;
  logic [ACC_W:0]            add_p2;

  assign d_ext  = {{ADC_W{in_data[ADC_W-1]}}, in_data};
  assign prod   = d_ext * d_ext;
  assign add_p2 = sat_add(acc_p2, sq_p1);

  // ---- stage 1: square register ----
  // Control bits of the square stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
    end else begin
      vld_p1  <= in_vld;
      last_p1 <= in_vld && in_last;
    end
  end

  // Square of the accepted sample; always non-negative so stored unsigned.
  always_ff @(posedge clk) begin
    if (in_vld) sq_p1 <= prod;
  end

  // ---- stage 2: saturating accumulate and publish ----
  // Flush discards whatever square is in flight and restarts the window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_p2     <= '0;
      sat_win_p2 <= 1'b0;
      sum_out    <= '0;
      dump_valid <= 1'b0;
      dump_cnt   <= '0;
      sat_flag   <= 1'b0;
    end else begin
      dump_valid <= 1'b0;
      if (flush) begin
        acc_p2     <= '0;
        sat_win_p2 <= 1'b0;
      end else if (vld_p1) begin
        if (last_p1) begin
          sum_out    <= add_p2[ACC_W-1:0];
          sat_flag   <= sat_win_p2 | add_p2[ACC_W];
          dump_valid <= 1'b1;
          dump_cnt   <= dump_cnt + 16'd1;
          acc_p2     <= '0;
          sat_win_p2 <= 1'b0;
        end else begin
          acc_p2     <= add_p2[ACC_W-1:0];
          sat_win_p2 <= sat_win_p2 | add_p2[ACC_W];
        end
      end
    end
  end

endmodule

// File: rtl/adc_sum_sq_ctrl.sv
// ADC power monitor sequencer: window FSM and valid-sample counter in front
// of the square/accumulate datapath.
module adc_sum_sq_ctrl #(
  parameter int ADC_W   = 8,
  parameter int ACC_W   = 32,
  parameter int LEN_W   = 5,
  parameter int LEN_MIN = adc_ctrl_pkg::LEN_MIN,
  parameter int LEN_MAX = adc_ctrl_pkg::LEN_MAX
) (
  input  logic                    user_clk,
  input  logic                    user_rst_n,
  input  logic                    adc_valid,
  input  logic signed [ADC_W-1:0] adc_data,
  input  logic                    sync_in,
  input  logic                    ctrl_en,
  input  logic                    ctrl_resync,
  input  logic [LEN_W-1:0]        acc_len,
  output logic [ACC_W-1:0]        user_data_in,
  output logic                    dump_valid,
  output logic [15:0]             dump_cnt,
  output logic                    sat_flag,
  output logic [1:0]              state_out
);

  localparam logic [LEN_MAX:0]   SPAN_ONE = {{LEN_MAX{1'b0}}, 1'b1};
  localparam logic [LEN_MAX-1:0] CNT_ONE  = {{(LEN_MAX-1){1'b0}}, 1'b1};

  adc_ctrl_pkg::state_t state, state_nxt;

  logic [LEN_W-1:0]   len_l;
  logic [LEN_W-1:0]   len_new;
  logic [LEN_W-1:0]   len_eff;
  logic [LEN_MAX-1:0] cnt;
  logic [LEN_MAX-1:0] cnt_eff;
  logic [LEN_MAX:0]   span;
  logic               start;
  logic               resync;
  logic               restart;
  logic               take;
  logic               is_last;
  logic               flush;

  assign len_new = LEN_W'(adc_ctrl_pkg::clamp_len(32'(acc_len), LEN_MIN, LEN_MAX));

  // A window (re)starts on sync in WAIT_SYNC, or on resync-enabled sync in ACCUM.
  assign start   = ctrl_en && (state == adc_ctrl_pkg::WAIT_SYNC) && sync_in;
  assign resync  = ctrl_en && (state == adc_ctrl_pkg::ACCUM) && ctrl_resync && sync_in;
  assign restart = start || resync;
  assign take    = ctrl_en && adc_valid && ((state == adc_ctrl_pkg::ACCUM) || start);

  // On a restart cycle the sample is judged against the fresh window.
  assign len_eff = restart ? len_new : len_l;
  assign cnt_eff = restart ? '0 : cnt;
  assign span    = (SPAN_ONE << len_eff) - SPAN_ONE;
  assign is_last = take && (cnt_eff == span[LEN_MAX-1:0]);
  assign flush   = !ctrl_en || restart;

  assign state_out = state;

  // State register.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) state <= adc_ctrl_pkg::IDLE;
    else             state <= state_nxt;
  end

  // Next-state decode; disable always wins.
  always_comb begin
    state_nxt = state;
    if (!ctrl_en) begin
      state_nxt = adc_ctrl_pkg::IDLE;
    end else begin
      case (state)
        adc_ctrl_pkg::IDLE:      state_nxt = adc_ctrl_pkg::WAIT_SYNC;
        adc_ctrl_pkg::WAIT_SYNC: if (sync_in) state_nxt = adc_ctrl_pkg::ACCUM;
        adc_ctrl_pkg::ACCUM:     state_nxt = adc_ctrl_pkg::ACCUM;
        default:                 state_nxt = adc_ctrl_pkg::IDLE;
      endcase
    end
  end

  // Valid-sample counter and latched window length.
  always_ff @(posedge user_clk or negedge user_rst_n) begin
    if (!user_rst_n) begin
      cnt   <= '0;
      len_l <= LEN_W'(LEN_MIN);
    end else begin
      if (!ctrl_en || ((state != adc_ctrl_pkg::ACCUM) && !start)) cnt <= '0;
      else if (take && !is_last)                                 cnt <= cnt_eff + CNT_ONE;
      else if (take || restart)                                  cnt <= '0;
      if (restart || is_last) len_l <= len_new;
    end
  end

  sum_sq_pipe #(
    .ADC_W (ADC_W),
    .ACC_W (ACC_W)
  ) u_pipe (
    .clk        (user_clk),
    .rst_n      (user_rst_n),
    .flush      (flush),
    .in_vld     (take),
    .in_last    (is_last),
    .in_data    (adc_data),
    .sum_out    (user_data_in),
    .dump_valid (dump_valid),
    .dump_cnt   (dump_cnt),
    .sat_flag   (sat_flag)
  );

endmodule

// File: tb/tb_adc_sum_sq_ctrl.sv
// Directed bench for adc_sum_sq_ctrl with a dump scoreboard; a 32-bit and a
// 16-bit accumulator build run side by side on the same stimulus.
module tb_adc_sum_sq_ctrl;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              adc_valid;
  logic signed [7:0] adc_data;
  logic              sync_in;
  logic              ctrl_en;
  logic              ctrl_resync;
  logic [4:0]        acc_len;

  logic [31:0] ud32;
  logic        dv32;
  logic [15:0] dc32;
  logic        sf32;
  logic [1:0]  st32;
  logic [15:0] ud16;
  logic        dv16;
  logic [15:0] dc16;
  logic        sf16;
  logic [1:0]  st16;

  always #5 clk = ~clk;

  adc_sum_sq_ctrl #(.ACC_W(32)) dut (
    .user_clk(clk), .user_rst_n(rst_n), .adc_valid(adc_valid), .adc_data(adc_data),
    .sync_in(sync_in), .ctrl_en(ctrl_en), .ctrl_resync(ctrl_resync), .acc_len(acc_len),
    .user_data_in(ud32), .dump_valid(dv32), .dump_cnt(dc32), .sat_flag(sf32),
    .state_out(st32));

  adc_sum_sq_ctrl #(.ACC_W(16)) dut16 (
    .user_clk(clk), .user_rst_n(rst_n), .adc_valid(adc_valid), .adc_data(adc_data),
    .sync_in(sync_in), .ctrl_en(ctrl_en), .ctrl_resync(ctrl_resync), .acc_len(acc_len),
    .user_data_in(ud16), .dump_valid(dv16), .dump_cnt(dc16), .sat_flag(sf16),
    .state_out(st16));

  typedef struct {
    logic [31:0] d32;
    logic        s32;
    logic [15:0] d16;
    logic        s16;
    logic [15:0] cnt;
    int          cyc;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          last_cyc = 0;
  logic [15:0] exp_cnt = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Drive one cycle of inputs just after the active edge.
  task automatic step(input logic v, input logic signed [7:0] d, input logic s);
    adc_valid = v;
    adc_data  = d;
    sync_in   = s;
    last_cyc  = cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic signed [7:0] d);
    for (int i = 0; i < n; i++) step(1'b1, d, 1'b0);
  endtask

  // Queue the dump due two cycles after the last sample just driven.
  task automatic expect_dump(input logic [31:0] d32, input logic s32,
                             input logic [15:0] d16, input logic s16);
    exp_t e;
    exp_cnt = exp_cnt + 16'd1;
    e.d32 = d32;
    e.s32 = s32;
    e.d16 = d16;
    e.s16 = s16;
    e.cnt = exp_cnt;
    e.cyc = last_cyc + 2;
    q.push_back(e);
  endtask

  // Monitor: every dump pulse is matched against the head of the queue.
  always @(negedge clk) begin
    if (dv32 || dv16) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_dump: got sum %0d, expected no dump (cycle %0d)", ud32, cyc);
      end else begin
        mon_e = q.pop_front();
        chk("dump_valid32", {31'd0, dv32}, 32'd1);
        chk("dump_valid16", {31'd0, dv16}, 32'd1);
        chk("sum32", ud32, mon_e.d32);
        chk("sat32", {31'd0, sf32}, {31'd0, mon_e.s32});
        chk("sum16", {16'd0, ud16}, {16'd0, mon_e.d16});
        chk("sat16", {31'd0, sf16}, {31'd0, mon_e.s16});
        chk("dump_cnt", {16'd0, dc32}, {16'd0, mon_e.cnt});
        chk("latency", cyc, mon_e.cyc);
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    adc_valid   = 1'b0;
    adc_data    = '0;
    sync_in     = 1'b0;
    ctrl_en     = 1'b0;
    ctrl_resync = 1'b0;
    acc_len     = 5'd4;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sum", ud32, 32'd0);
    chk("rst_dump_valid", {31'd0, dv32}, 32'd0);
    chk("rst_dump_cnt", {16'd0, dc32}, 32'd0);
    chk("rst_sat", {31'd0, sf32}, 32'd0);
    chk("rst_state", {30'd0, st32}, 32'd0);

    rst_n   = 1'b1;
    ctrl_en = 1'b1;
    @(posedge clk);
    #1;
    chk("state_wait_sync", {30'd0, st32}, 32'd1);

    // Basic window: 16 x (+3), sync sample is sample 0.
    step(1'b1, 8'sd3, 1'b1);
    run(15, 8'sd3);
    expect_dump(32'd144, 1'b0, 16'd144, 1'b0);
    chk("state_accum", {30'd0, st32}, 32'd2);

    // Extreme value; saturates only the 16-bit build.
    run(16, -8'sd128);
    expect_dump(32'd262144, 1'b0, 16'd65535, 1'b1);

    // Back-to-back ramp 1..32.
    for (int i = 1; i <= 32; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == 16) expect_dump(32'd1496, 1'b0, 16'd1496, 1'b0);
      if (i == 32) expect_dump(32'd9944, 1'b0, 16'd9944, 1'b0);
    end

    // Resync at sample 10: partial window of 5s dropped, new window 7 + 15x1.
    ctrl_resync = 1'b1;
    run(10, 8'sd5);
    step(1'b1, 8'sd7, 1'b1);
    run(15, 8'sd1);
    expect_dump(32'd64, 1'b0, 16'd64, 1'b0);
    ctrl_resync = 1'b0;

    // Gapped window of 4s; a sync with resync off must be ignored.
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'sd4, (i == 5) ? 1'b1 : 1'b0);
      if (i == 15) expect_dump(32'd256, 1'b0, 16'd256, 1'b0);
      step(1'b0, 8'sd0, 1'b0);
    end
    step(1'b0, 8'sd0, 1'b0);

    // Disable mid-window: back to IDLE, published values hold.
    run(5, 8'sd9);
    ctrl_en = 1'b0;
    step(1'b1, 8'sd9, 1'b0);
    chk("disable_state", {30'd0, st32}, 32'd0);
    repeat (3) step(1'b0, 8'sd0, 1'b0);
    chk("disable_hold_sum", ud32, 32'd256);
    chk("disable_hold_cnt", {16'd0, dc32}, {16'd0, exp_cnt});

    // acc_len=2 clamps to a 16-sample window.
    acc_len = 5'd2;
    ctrl_en = 1'b1;
    step(1'b0, 8'sd0, 1'b0);
    step(1'b1, 8'sd6, 1'b1);
    run(15, 8'sd6);
    expect_dump(32'd576, 1'b0, 16'd576, 1'b0);
    repeat (4) step(1'b0, 8'sd0, 1'b0);

    // Asynchronous reset mid-window.
    run(4, 8'sd3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_sum", ud32, 32'd0);
    chk("arst_sum16", {16'd0, ud16}, 32'd0);
    chk("arst_dump_cnt", {16'd0, dc32}, 32'd0);
    chk("arst_sat", {31'd0, sf32}, 32'd0);
    chk("arst_state", {30'd0, st32}, 32'd0);
    exp_cnt = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(20, 8'sd3);
    chk("post_rst_state", {30'd0, st32}, 32'd1);
    chk("post_rst_cnt", {16'd0, dc32}, 32'd0);

    repeat (4) step(1'b0, 8'sd0, 1'b0);
    chk("queue_empty", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
